// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: stores round keys 0..10 behind a combinational read port.
// Round keys complete 10 cycles after key accept; key_ready is low for the whole expansion and key is never queued.
module aes128_key_expand (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [127:0] key,
  output logic         key_ready,
  output logic         keys_valid,
  output logic         busy,
  input  logic [3:0]   rk_round,
  output logic [127:0] rk_data
);

  typedef enum logic [1:0] {IDLE, EXPAND, VALID} state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_t       state;
  logic [3:0]   cnt;
  logic [7:0]   rcon;
  logic [127:0] rk [0:10];

  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  rot;
  logic [31:0]  t;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon_next;

  // cnt is 1..10 while expanding; the clamp only matters for the idle value of 0
  always_comb begin
    prev_idx  = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    prev      = rk[prev_idx];
    rot       = {prev[23:0], prev[31:24]};
    t         = {SBOX[rot[31:24]] ^ rcon, SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    n0        = prev[127:96] ^ t;
    n1        = prev[95:64] ^ n0;
    n2        = prev[63:32] ^ n1;
    n3        = prev[31:0] ^ n2;
    rcon_next = {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});
  end

  always_comb begin
    rk_data = '0;
    if (rk_round <= 4'd10) rk_data = rk[rk_round];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rcon       <= '0;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      case (state)
        IDLE, VALID: begin
          if (key_valid) begin
            rk[0]      <= key;
            rcon       <= 8'h01;
            cnt        <= 4'd1;
            state      <= EXPAND;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
          end
        end
        EXPAND: begin
          rk[cnt] <= {n0, n1, n2, n3};
          rcon    <= rcon_next;
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd10) begin
            state      <= VALID;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          key_ready  <= 1'b1;
          busy       <= 1'b0;
          keys_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_key_expand.sv
// Randomized check of aes128_key_expand against a word-level FIPS-197 key schedule model.
module tb_aes128_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid;
  logic [127:0] key;
  logic         key_ready;
  logic         keys_valid;
  logic         busy;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]   sbox_m [0:255];
  logic [127:0] exp_rk [0:10];

  aes128_key_expand dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key        (key),
    .key_ready  (key_ready),
    .keys_valid (keys_valid),
    .busy       (busy),
    .rk_round   (rk_round),
    .rk_data    (rk_data)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse in GF(2^8), then the affine map
  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      if (x != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, x);
      end
      sbox_m[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic sweep(input string tag);
    for (int r = 0; r < 16; r++) begin
      rk_round = 4'(r);
      #1;
      chk($sformatf("%s_rk%0d", tag, r), rk_data, (r <= 10) ? exp_rk[r] : 128'h0);
    end
  endtask

  function automatic logic [127:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept k, optionally holding key_valid high with junk during the expansion, and
  // verify handshake timing: keys_valid rises exactly 10 edges after the accepting edge.
  task automatic run_key(input string tag, input logic [127:0] k, input bit hold_junk);
    logic [127:0] junk;
    junk = rnd_key();
    model(k);
    key_valid = 1'b1;
    key = k;
    tick();
    chk({tag, "_acc_state"}, {125'h0, busy, key_ready, keys_valid}, {125'h0, 3'b100});
    key_valid = hold_junk;
    key = junk;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i < 10)
        chk($sformatf("%s_exp%0d", tag, i), {126'h0, key_ready, keys_valid}, 128'h0);
    end
    chk({tag, "_done_state"}, {125'h0, busy, key_ready, keys_valid}, {125'h0, 3'b011});
    sweep(tag);
  endtask

  initial begin
    logic [127:0] k;
    reset = 1'b1; key_valid = 1'b0; key = '0; rk_round = '0;
    build_sbox();
    tick(); tick();
    reset = 1'b0;
    chk("reset_state", {125'h0, busy, key_ready, keys_valid}, {125'h0, 3'b010});
    exp_rk = '{default: 128'h0};
    sweep("reset");

    run_key("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    rk_round = 4'd1;  #1; chk("fips_const_rk1", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
    rk_round = 4'd10; #1; chk("fips_const_rk10", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_key("zero", 128'h0, 1'b0);
    rk_round = 4'd1;  #1; chk("zero_const_rk1", rk_data, 128'h62636363626363636263636362636363);
    rk_round = 4'd10; #1; chk("zero_const_rk10", rk_data, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // second key offered throughout the expansion must be ignored; then accepted from VALID
    run_key("hold", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    run_key("from_valid", rnd_key(), 1'b0);

    // reset sampled at the fifth expansion edge
    k = rnd_key();
    key_valid = 1'b1; key = k;
    tick();
    key_valid = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    chk("pre_abort_busy", {127'h0, busy}, 128'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_state", {125'h0, busy, key_ready, keys_valid}, {125'h0, 3'b010});
    exp_rk = '{default: 128'h0};
    sweep("abort");
    run_key("after_abort", k, 1'b0);

    for (int j = 0; j < 3; j++) run_key($sformatf("rand%0d", j), rnd_key(), j[0]);
    key_valid = 1'b0;

    for (int i = 0; i < 100; i++) tick();
    chk("idle_state", {125'h0, busy, key_ready, keys_valid}, {125'h0, 3'b011});
    sweep("stable");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes128_key_expand.md
Name: aes128_key_expand

Overview:
Iterative AES-128 key schedule that feeds per-round keys to the AES round datapath. It replaces the current use of the raw cipher key in every AddRoundKey. It accepts a 128-bit cipher key through a valid/ready handshake and computes round keys 1..10 at one per clock. It stores all 11 round keys (0..10) and serves them through a combinational read port indexed by round number.

Parameters:
None. The block is AES-128 only, with Nk=4 and Nr=10 fixed.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
key_valid  input  1  cipher key presented on key this cycle
key  input  128  cipher key; key[127:96]=w0 … key[31:0]=w3; byte [127:120] is byte 0
key_ready  output  1  block can accept a new key
keys_valid  output  1  round keys 0..10 are complete and stable
busy  output  1  expansion in progress
rk_round  input  4  round-key index to read (0..15)
rk_data  output  128  round key for rk_round; same column/byte ordering as key

Behaviour:
- Reset (sampled on clk rising edge while reset=1):
  - state=IDLE, round counter=0, keys_valid=0, busy=0, key_ready=1.
  - All 11 round-key registers are cleared to 0.
  - Reset wins over every other input in the same cycle.
- States: IDLE, EXPAND, VALID.
  - key_ready=1 in IDLE and VALID; 0 in EXPAND.
  - busy=1 only in EXPAND.
  - keys_valid=1 only in VALID.
- Accept: key_valid && key_ready at edge E0.
  - rk[0] <= key; rcon <= 8'h01; cnt <= 1; state <= EXPAND.
  - keys_valid drops to 0 after E0, including when accepted from VALID.
  - key is not sampled in any other cycle.
- EXPAND, one round key per edge E1..E10. At edge En, with p = rk[n-1] = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the standard AES forward S-box to each of the 4 bytes. The block has its own 4-instance S-box; it shares nothing with the datapath.
  - n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2; rk[n] <= {n0,n1,n2,n3}.
  - rcon <= xtime(rcon) = {rcon[6:0],1'b0} ^ (8'h1b & {8{rcon[7]}}).
  - Resulting rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - cnt <= cnt+1.
  - At E10 (cnt==10): state <= VALID, so keys_valid=1 from the cycle after E10.
  - Latency: 10 cycles after the accepting edge.
- key_valid during EXPAND is ignored. It is not queued, and the expansion is not disturbed.
- Read port (combinational, zero latency):
  - rk_data = rk[rk_round] for rk_round 0..10.
  - rk_data = 128'h0 for rk_round 11..15.
  - During EXPAND, rk_data shows whatever is currently stored. Entries n<cnt are already new; the rest are stale or zero. Consumers must gate on keys_valid.
- VALID holds indefinitely. All rk entries stay constant until the next accept or reset.
- Reset mid-EXPAND aborts the expansion, clears storage, and returns to IDLE the next cycle.

Test Plan:
- Reset, then FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted at E0:
  - key_ready=0 for 10 cycles; keys_valid=1 after E10.
  - rk[0]=key; rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - rk[1]=62636363626363636263636362636363; rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- key_valid held high with a different key during EXPAND:
  - The second key is ignored; results match the first key's vector.
  - A new key is accepted in VALID: keys_valid=0 next cycle, then the new vector is complete 10 cycles later.
- reset asserted at E5 of an expansion:
  - Next cycle: IDLE, key_ready=1, keys_valid=0, rk_data=0 for every rk_round.
  - A fresh accept then produces correct keys.
- In VALID, sweep rk_round 0..15:
  - 0..10 return the expected keys; 11..15 return 0.
  - Values stay stable over 100 idle cycles with key_valid=0.
